pll_sequencer: RTL and testbench
================================

# pll_sequencer

Sequences one Gowin rPLL in the mister_ng clocking layer. It drives the PLL's RESET and dynamic divider selects (IDSEL/FBDSEL/ODSEL) and qualifies LOCK. It retries failed locks, reports a fault after repeated failures, and generates the downstream system reset. It runs on the free-running reference clock that also feeds the PLL's CLKIN.

## Interface
Parameters:
- RESET_CYCLES, 16: cycles pll_reset is held per attempt (≥1).
- LOCK_STABLE, 1024: consecutive synchronised-lock cycles required before declaring lock (≥1).
- LOCK_TIMEOUT, 65536: cycles allowed from pll_reset release to lock declaration (> LOCK_STABLE+2).
- MAX_RETRY, 3: failed attempts before fault (1..15).
- DEF_IDSEL / DEF_FBDSEL / DEF_ODSEL, 6'd0: divider selects driven out of reset.

Ports:
- CLKIN in 1: reference clock; all logic on its rising edge.
- RESET in 1: asynchronous, active-high.
- cfg_req in 1: reconfiguration request, level.
- cfg_idsel, cfg_fbdsel, cfg_odsel in 6 each: new selects, sampled with cfg_req.
- cfg_ack out 1: one-cycle pulse when a request is accepted.
- pll_lock in 1: raw PLL LOCK; asynchronous.
- pll_reset out 1: to the PLL's RESET.
- pll_idsel, pll_fbdsel, pll_odsel out 6 each: to the PLL's IDSEL/FBDSEL/ODSEL.
- locked out 1: qualified lock.
- sys_reset out 1: active-high reset for logic clocked by the PLL.
- fault out 1: retries exhausted.
- retry_cnt out 4: failed attempts in the current sequence.

## Operation
- pll_lock passes through a 2-flop synchroniser (lock_s). Nothing uses raw pll_lock.
- Reset values: state S_RST, counters 0, pll_reset=1, sys_reset=1, locked=0, fault=0, cfg_ack=0, retry_cnt=0, sel outputs = DEF_*.
- The counter width is sized for the largest of RESET_CYCLES, LOCK_STABLE and LOCK_TIMEOUT. Counters saturate and never wrap.
- S_RST: pll_reset=1 and the counter increments each cycle. Once the count reaches RESET_CYCLES, clear the counter and go to S_WAIT.
- S_WAIT: pll_reset=0.
  - The timeout counter increments each cycle.
  - lock_s=1 starts the stable count at 1 and moves to S_STABLE.
- S_STABLE: the stable counter increments while lock_s=1.
  - lock_s=0 returns to S_WAIT and clears the stable count. The timeout count keeps running.
  - Stable count == LOCK_STABLE moves to S_RUN.
- Timeout: timeout count reaches LOCK_TIMEOUT in S_WAIT or S_STABLE.
  - retry_cnt increments.
  - If the new value equals MAX_RETRY, go to S_FAULT; otherwise go to S_RST.
  - If timeout and stable completion occur in the same cycle, completion wins.
- S_RUN: locked=1, sys_reset=0, pll_reset=0.
- S_FAULT: fault=1, pll_reset=1, sys_reset=1, locked=0. The state holds until RESET or an accepted cfg_req.
- cfg_req is accepted only in S_RUN or S_FAULT. In other states it is ignored; a held request is accepted on arrival in S_RUN.
- On acceptance:
  - The cfg_* selects latch onto the pll_* outputs.
  - cfg_ack pulses for that cycle.
  - retry_cnt and fault clear.
  - The next state is S_RST.
  - locked falls and sys_reset rises on the cycle after the accepting edge.
- Selects change only on acceptance or RESET, so they are always stable while pll_reset is high.
- RESET mid-sequence aborts immediately to the reset values. The previously configured selects are lost and revert to DEF_*.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- RESET deassertion to pll_reset falling: RESET_CYCLES edges.
- pll_lock sustained high to locked=1: LOCK_STABLE+3 edges.
  - 2 edges for the synchroniser.
  - 1 edge for S_WAIT to S_STABLE.
  - LOCK_STABLE edges to reach S_RUN.
- cfg_req sampled high in S_RUN: cfg_ack and the new selects appear after 1 edge; pll_reset=1 after 1 edge.
- Lock loss in S_RUN, behaviour depends on the macro (see Configuration):
  - Either response takes effect 3 edges after pll_lock falls.

## Configuration
- PLL_SEQ_AUTO_RELOCK_EN defined:
  - lock_s=0 in S_RUN goes to S_RST.
  - locked=0 and sys_reset=1 from the next cycle.
  - retry_cnt clears.
- PLL_SEQ_AUTO_RELOCK_EN undefined:
  - S_RUN is left only by an accepted cfg_req or RESET.
  - locked = registered (S_RUN & lock_s).
  - sys_reset stays 0.

## Structure
- Shared package pll_seq_pkg holds:
  - state enum {S_RST, S_WAIT, S_STABLE, S_RUN, S_FAULT};
  - localparam PLL_SEL_W=6;
  - a struct bundling idsel/fbdsel/odsel.
- One sub-module, sync_2ff: a generic 2-flop synchroniser with asynchronous reset to 0, instanced for pll_lock.

## Test plan
Bench parameters: RESET_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2.
- Cold start: release RESET, raise pll_lock 2 cycles after pll_reset falls → pll_reset high 4 edges, locked=1 and sys_reset=0 exactly 11 edges after pll_lock rises, retry_cnt=0.
- Glitching lock: toggle pll_lock low for 1 cycle at stable count 5 → stable count restarts, locked delayed by a further 8+ edges, no retry.
- Lock never asserts → two 32-cycle timeouts, retry_cnt reaches 2, fault=1, pll_reset=1, sys_reset=1 held.
- Reconfigure in S_RUN: cfg_req with idsel=3, fbdsel=9, odsel=8 → one-cycle cfg_ack, pll_* show 3/9/8 while pll_reset is high, relock completes, fault stays 0.
- Recovery from fault: cfg_req in S_FAULT → fault clears, retry_cnt=0, a new sequence starts. cfg_req raised during S_WAIT → no ack until S_RUN.
- Lock loss in S_RUN: drop pll_lock. With PLL_SEQ_AUTO_RELOCK_EN → sys_reset=1 three edges later and the sequence restarts. Without it → locked=0 three edges later and sys_reset stays 0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, select width and select bundle
// for the rPLL sequencer.
package pll_seq_pkg;

    localparam int PLL_SEL_W = 6;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    typedef struct packed {
        logic [PLL_SEL_W-1:0] idsel;
        logic [PLL_SEL_W-1:0] fbdsel;
        logic [PLL_SEL_W-1:0] odsel;
    } pll_sel_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchroniser, asynchronous reset to 0.
// Used to bring the raw PLL lock into the reference clock domain.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // two back-to-back flops; only q is safe to use
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_sequencer.sv
// pll_sequencer: resets one rPLL, drives its divider selects, qualifies
// lock, retries and faults. Optional: PLL_SEQ_AUTO_RELOCK_EN.
module pll_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 3,
    parameter logic [PLL_SEL_W-1:0] DEF_IDSEL  = 6'd0,
    parameter logic [PLL_SEL_W-1:0] DEF_FBDSEL = 6'd0,
    parameter logic [PLL_SEL_W-1:0] DEF_ODSEL  = 6'd0
) (
    input  logic                 CLKIN,
    input  logic                 RESET,
    input  logic                 cfg_req,
    input  logic [PLL_SEL_W-1:0] cfg_idsel,
    input  logic [PLL_SEL_W-1:0] cfg_fbdsel,
    input  logic [PLL_SEL_W-1:0] cfg_odsel,
    output logic                 cfg_ack,
    input  logic                 pll_lock,
    output logic                 pll_reset,
    output logic [PLL_SEL_W-1:0] pll_idsel,
    output logic [PLL_SEL_W-1:0] pll_fbdsel,
    output logic [PLL_SEL_W-1:0] pll_odsel,
    output logic                 locked,
    output logic                 sys_reset,
    output logic                 fault,
    output logic [3:0]           retry_cnt
);

    localparam int CNT_W =
        $clog2(max3(RESET_CYCLES, LOCK_STABLE, LOCK_TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_DONE = CNT_W'(LOCK_STABLE);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]       RTY_LIM  = 4'(MAX_RETRY);
    localparam pll_sel_t DEF_SEL = '{
        idsel:  DEF_IDSEL,
        fbdsel: DEF_FBDSEL,
        odsel:  DEF_ODSEL
    };

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] stab;
    logic [3:0]       retry_next;
    pll_sel_t         sel;
    logic             lock_s;
    logic             accept;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk (CLKIN),
        .rst (RESET),
        .d   (pll_lock),
        .q   (lock_s)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    assign accept     = cfg_req && (state == S_RUN || state == S_FAULT);
    assign retry_next = retry_cnt + 4'd1;
    assign pll_idsel  = sel.idsel;
    assign pll_fbdsel = sel.fbdsel;
    assign pll_odsel  = sel.odsel;

    // sequencer: reset hold, lock qualification, retry/fault, reconfig
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state     <= S_RST;
            cnt       <= '0;
            stab      <= '0;
            sel       <= DEF_SEL;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            locked    <= 1'b0;
            fault     <= 1'b0;
            cfg_ack   <= 1'b0;
            retry_cnt <= 4'd0;
        end else begin
            cfg_ack <= 1'b0;
            if (accept) begin
                sel       <= '{idsel: cfg_idsel, fbdsel: cfg_fbdsel,
                               odsel: cfg_odsel};
                cfg_ack   <= 1'b1;
                retry_cnt <= 4'd0;
                fault     <= 1'b0;
                state     <= S_RST;
                cnt       <= '0;
                stab      <= '0;
                pll_reset <= 1'b1;
                sys_reset <= 1'b1;
                locked    <= 1'b0;
            end else begin
                unique case (state)
                    S_RST: begin
                        if (cnt == RST_LAST) begin
                            cnt       <= '0;
                            state     <= S_WAIT;
                            pll_reset <= 1'b0;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                    S_WAIT, S_STABLE: begin
                        cnt <= sat_inc(cnt);
                        if (state == S_STABLE && lock_s
                            && stab == STB_DONE) begin
                            // completion beats a coincident timeout
                            state     <= S_RUN;
                            locked    <= 1'b1;
                            sys_reset <= 1'b0;
                            cnt       <= '0;
                            stab      <= '0;
                        end else if (cnt == TMO_LAST) begin
                            retry_cnt <= retry_next;
                            cnt       <= '0;
                            stab      <= '0;
                            pll_reset <= 1'b1;
                            if (retry_next == RTY_LIM) begin
                                state <= S_FAULT;
                                fault <= 1'b1;
                            end else begin
                                state <= S_RST;
                            end
                        end else if (lock_s) begin
                            state <= S_STABLE;
                            stab  <= (state == S_STABLE) ? sat_inc(stab) : ONE;
                        end else begin
                            state <= S_WAIT;
                            stab  <= '0;
                        end
                    end
                    S_RUN: begin
`ifdef PLL_SEQ_AUTO_RELOCK_EN
                        if (!lock_s) begin
                            state     <= S_RST;
                            cnt       <= '0;
                            locked    <= 1'b0;
                            sys_reset <= 1'b1;
                            pll_reset <= 1'b1;
                            retry_cnt <= 4'd0;
                        end
`else
                        locked <= lock_s;
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_sequencer.sv
// tb_pll_sequencer: directed flow with randomised lock patterns and
// selects; expected lock edges come from a sliding-window lock model.
module tb_pll_sequencer;

    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int MR = 2;
    localparam logic [5:0] D_ID = 6'd5;
    localparam logic [5:0] D_FB = 6'd10;
    localparam logic [5:0] D_OD = 6'd20;

    logic       CLKIN = 1'b0;
    logic       RESET;
    logic       cfg_req;
    logic [5:0] cfg_idsel;
    logic [5:0] cfg_fbdsel;
    logic [5:0] cfg_odsel;
    logic       cfg_ack;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       locked;
    logic       sys_reset;
    logic       fault;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;
    int exp_retry = 0;
    bit pat [0:LT-1];

    pll_sequencer #(
        .RESET_CYCLES (RC),
        .LOCK_STABLE  (LS),
        .LOCK_TIMEOUT (LT),
        .MAX_RETRY    (MR),
        .DEF_IDSEL    (D_ID),
        .DEF_FBDSEL   (D_FB),
        .DEF_ODSEL    (D_OD)
    ) dut (
        .CLKIN      (CLKIN),
        .RESET      (RESET),
        .cfg_req    (cfg_req),
        .cfg_idsel  (cfg_idsel),
        .cfg_fbdsel (cfg_fbdsel),
        .cfg_odsel  (cfg_odsel),
        .cfg_ack    (cfg_ack),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .locked     (locked),
        .sys_reset  (sys_reset),
        .fault      (fault),
        .retry_cnt  (retry_cnt)
    );

    always #5 CLKIN = ~CLKIN;

    task automatic tick();
        @(posedge CLKIN);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] obs();
        return {locked, sys_reset, pll_reset, cfg_ack, fault, retry_cnt};
    endfunction

    function automatic logic [8:0] mk(input bit l, input bit s, input bit p,
                                      input bit a, input bit f, input int r);
        return {l, s, p, a, f, 4'(r)};
    endfunction

    task automatic chk_out(input string tag, input logic [8:0] exp);
        chk(tag, 32'(obs()), 32'(exp));
    endtask

    task automatic chk_sel(input string tag, input logic [5:0] id,
                           input logic [5:0] fb, input logic [5:0] od);
        chk(tag, 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({id, fb, od}));
    endtask

    // Lock is declared once LS+1 consecutive samples are high; the
    // synchroniser adds 2 edges. Returns edges after release, or -1.
    function automatic int lock_offset();
        int run;
        run = 0;
        for (int i = 0; i < LT; i++) begin
            run = pat[i] ? run + 1 : 0;
            if (run == LS + 1 && i + 3 <= LT)
                return i + 3;
        end
        return -1;
    endfunction

    task automatic pat_lock(input int s, input int g);
        for (int i = 0; i < LT; i++)
            pat[i] = (i >= s) && (i != g);
    endtask

    task automatic pat_none();
        for (int i = 0; i < LT; i++)
            pat[i] = (i % 5 != 4) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic wait_fall(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (pll_reset === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    // called at the sample point right after pll_reset fell
    task automatic attempt(input string tag);
        int e_off;
        e_off = lock_offset();
        for (int o = 1; o <= LT; o++) begin
            pll_lock = pat[o-1];
            tick();
            if (o == e_off) begin
                chk_out({tag, " lock"}, mk(1, 0, 0, 0, 0, exp_retry));
                pll_lock = 1'b1;
                break;
            end
            if (o == LT) begin
                exp_retry++;
                chk_out({tag, " timeout"},
                        mk(0, 1, 1, 0, exp_retry == MR, exp_retry));
                pll_lock = 1'b0;
                break;
            end
            chk_out({tag, " wait"}, mk(0, 1, 0, 0, 0, exp_retry));
        end
    endtask

    task automatic reconfig(input logic [5:0] id, input logic [5:0] fb,
                            input logic [5:0] od, input string tag);
        int n;
        cfg_idsel  = id;
        cfg_fbdsel = fb;
        cfg_odsel  = od;
        cfg_req    = 1'b1;
        tick();
        exp_retry = 0;
        chk_out({tag, " accept"}, mk(0, 1, 1, 1, 0, 0));
        chk_sel({tag, " sel"}, id, fb, od);
        cfg_req    = 1'b0;
        pll_lock   = 1'b0;
        cfg_idsel  = ~id;
        cfg_fbdsel = ~fb;
        cfg_odsel  = ~od;
        tick();
        chk_out({tag, " ack pulse"}, mk(0, 1, 1, 0, 0, 0));
        wait_fall(n);
        chk({tag, " reset len"}, 32'(n), 32'(RC - 1));
        chk_sel({tag, " sel hold"}, id, fb, od);
    endtask

    initial begin
        int n;
        logic [5:0] r1, r2, r3;
        RESET      = 1'b1;
        cfg_req    = 1'b0;
        cfg_idsel  = 6'd0;
        cfg_fbdsel = 6'd0;
        cfg_odsel  = 6'd0;
        pll_lock   = 1'b0;
        repeat (3) tick();
        chk_out("reset", mk(0, 1, 1, 0, 0, 0));
        chk_sel("reset sel", D_ID, D_FB, D_OD);

        RESET = 1'b0;
        wait_fall(n);
        chk("cold reset len", 32'(n), 32'(RC));
        pat_lock(2, -1);
        attempt("cold");
        tick();
        chk_out("cold hold", mk(1, 0, 0, 0, 0, 0));

        reconfig(6'd3, 6'd9, 6'd8, "cfg398");
        pat_lock(2, 7);
        attempt("glitch");

        r1 = 6'($urandom_range(0, 8));
        pat_lock(0, -1);
        reconfig(D_FB, D_OD, D_ID, "cfg2");
        pat_lock(int'(r1), int'(r1) + $urandom_range(1, LS - 1));
        attempt("rglitch");

        pll_lock = 1'b0;
        tick();
        tick();
        chk_out("loss early", mk(1, 0, 0, 0, 0, 0));
        tick();
`ifdef PLL_SEQ_AUTO_RELOCK_EN
        chk_out("loss relock", mk(0, 1, 1, 0, 0, 0));
        wait_fall(n);
        chk("relock reset len", 32'(n), 32'(RC));
        pat_lock($urandom_range(0, LT - LS - 3), -1);
        attempt("relock");
`else
        chk_out("loss", mk(0, 0, 0, 0, 0, 0));
        pll_lock = 1'b1;
        tick();
        tick();
        chk_out("regain early", mk(0, 0, 0, 0, 0, 0));
        tick();
        chk_out("regain", mk(1, 0, 0, 0, 0, 0));
`endif

        r1 = 6'($urandom_range(0, 63));
        r2 = 6'($urandom_range(0, 63));
        r3 = 6'($urandom_range(0, 63));
        reconfig(r1, r2, r3, "cfg rand");
        pat_none();
        attempt("to1");
        wait_fall(n);
        chk("retry reset len", 32'(n), 32'(RC));
        pat_none();
        attempt("to2");
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out("fault hold", mk(0, 1, 1, 0, 1, MR));
        end
        chk_sel("fault sel", r1, r2, r3);

        r1 = 6'($urandom_range(0, 63));
        r2 = 6'($urandom_range(0, 63));
        r3 = 6'($urandom_range(0, 63));
        reconfig(r1, r2, r3, "recover");
        r1 = 6'($urandom_range(0, 63));
        r2 = 6'($urandom_range(0, 63));
        r3 = 6'($urandom_range(0, 63));
        cfg_idsel  = r1;
        cfg_fbdsel = r2;
        cfg_odsel  = r3;
        cfg_req    = 1'b1;
        pat_lock($urandom_range(0, LT - LS - 3), -1);
        attempt("held");
        tick();
        chk_out("held accept", mk(0, 1, 1, 1, 0, 0));
        chk_sel("held sel", r1, r2, r3);
        cfg_req  = 1'b0;
        pll_lock = 1'b0;
        wait_fall(n);
        chk("held reset len", 32'(n), 32'(RC));
        pat_lock($urandom_range(0, LT - LS - 3), -1);
        attempt("final");

        reconfig(6'd33, 6'd44, 6'd55, "pre abort");
        repeat (3) tick();
        RESET = 1'b1;
        #1;
        chk_out("abort", mk(0, 1, 1, 0, 0, 0));
        chk_sel("abort sel", D_ID, D_FB, D_OD);
        tick();
        RESET = 1'b0;
        exp_retry = 0;
        wait_fall(n);
        chk("abort reset len", 32'(n), 32'(RC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
